// File: rtl/delay_pkg.sv
// Shared types and pointer arithmetic for the variable-delay tap reader.
// DELAY_INTERP_EN (see delay_tap_reader) selects the interpolating state sequence.
package delay_pkg;

  localparam int SAMPLE_WIDTH = 16;
  localparam int PTR_W        = 32;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  // One encoding covers both the plain and the interpolating sequence.
  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAP,
    OUT,
    READ_A,
    READ_B,
    CAP_B,
    MIX
  } tap_state_e;

  function automatic logic [PTR_W-1:0] ptr_sub(input logic [PTR_W-1:0] ptr,
                                               input logic [PTR_W-1:0] delay,
                                               input int               depth);
    return (ptr - delay) & PTR_W'(depth - 1);
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// A read of the address being written in the same cycle returns the new data.
module delay_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DELAY  = 1024
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [$clog2(MAX_DELAY)-1:0]  wr_addr,
  input  logic signed [DATA_WIDTH-1:0]  wr_data,
  input  logic [$clog2(MAX_DELAY)-1:0]  rd_addr,
  output logic signed [DATA_WIDTH-1:0]  rd_data
);

  logic signed [DATA_WIDTH-1:0] mem [MAX_DELAY];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/delay_tap_reader.sv
// Circular sample buffer with a variable-delay read tap and valid/ready output.
// Define DELAY_INTERP_EN to blend taps d and d+1 by the fractional delay frac_i.
module delay_tap_reader
  import delay_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DELAY  = 1024,
  parameter int FRAC_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic signed [DATA_WIDTH-1:0]  data_i,
  input  logic [$clog2(MAX_DELAY)-1:0]  delay_i,
  input  logic [FRAC_WIDTH-1:0]         frac_i,
  output logic signed [DATA_WIDTH-1:0]  data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          overrun_o
);

  localparam int          AW       = $clog2(MAX_DELAY);
  localparam logic [AW:0] FILL_MAX = (AW+1)'(MAX_DELAY);

  tap_state_e                   state;
  logic [AW-1:0]                wr_ptr;
  logic [AW-1:0]                rd_addr;
  logic [AW-1:0]                ram_addr;
  logic [AW:0]                  fill;
  logic [AW:0]                  fill_next;
  logic                         hit;
  logic                         wr_en;
  logic signed [DATA_WIDTH-1:0] ram_q;

  assign wr_en     = en & rst_n;
  assign fill_next = (fill == FILL_MAX) ? fill : fill + 1'b1;

  delay_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_DELAY  (MAX_DELAY)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (data_i),
    .rd_addr (ram_addr),
    .rd_data (ram_q)
  );

`ifdef DELAY_INTERP_EN
  logic [AW-1:0]                       rd_addr_b;
  logic                                hit_b;
  logic                                last_tap;
  logic [FRAC_WIDTH-1:0]               frac_q;
  logic signed [DATA_WIDTH-1:0]        samp_a;
  logic signed [DATA_WIDTH-1:0]        samp_b;
  logic signed [DATA_WIDTH:0]          diff;
  logic signed [DATA_WIDTH+FRAC_WIDTH+1:0] prod;
  logic signed [DATA_WIDTH-1:0]        mix;

  assign ram_addr = (state == READ_B) ? rd_addr_b : rd_addr;

  // The blend always lands between a and b, so truncating back to sample width is safe.
  assign diff = {samp_b[DATA_WIDTH-1], samp_b} - {samp_a[DATA_WIDTH-1], samp_a};
  assign prod = (DATA_WIDTH+FRAC_WIDTH+2)'(diff)
              * (DATA_WIDTH+FRAC_WIDTH+2)'($signed({1'b0, frac_q}));
  assign mix  = samp_a + DATA_WIDTH'(prod >>> FRAC_WIDTH);
`else
  logic unused_frac;

  assign ram_addr    = rd_addr;
  assign unused_frac = ^frac_i;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      fill      <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      // Writes always land; only the read request can be refused while busy.
      if (en) begin
        wr_ptr <= wr_ptr + 1'b1;
        fill   <= fill_next;
        if (state != IDLE) overrun_o <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (en) begin
            rd_addr <= AW'(ptr_sub(PTR_W'(wr_ptr), PTR_W'(delay_i), MAX_DELAY));
            hit     <= ({1'b0, delay_i} < fill_next);
`ifdef DELAY_INTERP_EN
            rd_addr_b <= AW'(ptr_sub(PTR_W'(wr_ptr), PTR_W'(delay_i) + 1, MAX_DELAY));
            hit_b     <= (({1'b0, delay_i} + 1'b1) < fill_next);
            last_tap  <= (delay_i == '1);
            frac_q    <= frac_i;
            state     <= READ_A;
`else
            state     <= READ;
`endif
          end
        end
`ifdef DELAY_INTERP_EN
        READ_A: state <= READ_B;
        READ_B: begin
          samp_a <= hit ? ram_q : '0;
          state  <= CAP_B;
        end
        // At the deepest tap the d+1 slot was just overwritten, so reuse a.
        CAP_B: begin
          samp_b <= last_tap ? samp_a : (hit_b ? ram_q : '0);
          state  <= MIX;
        end
        MIX: begin
          data_o  <= mix;
          valid_o <= 1'b1;
          state   <= OUT;
        end
`else
        READ: state <= CAP;
        CAP: begin
          data_o  <= hit ? ram_q : '0;
          valid_o <= 1'b1;
          state   <= OUT;
        end
`endif
        OUT: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_tap_reader.sv
// Directed bench for delay_tap_reader (MAX_DELAY=16); define DELAY_INTERP_EN
// to also exercise the fractional blend and its longer latency.
module tb_delay_tap_reader;
  import delay_pkg::*;

  localparam int DATA_WIDTH = 16;
  localparam int MAX_DELAY  = 16;
  localparam int FRAC_WIDTH = 4;
  // Edges from the en-sampling edge until valid_o is seen high.
`ifdef DELAY_INTERP_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    bit do_reset;
    int data;
    int dly;
    int frac;
    int exp_data;
  } vec_t;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         en = 1'b0;
  sample_t                      data_i = '0;
  logic [$clog2(MAX_DELAY)-1:0] delay_i = '0;
  logic [FRAC_WIDTH-1:0]        frac_i = '0;
  sample_t                      data_o;
  logic                         valid_o;
  logic                         ready_i = 1'b1;
  logic                         overrun_o;

  int vectors = 0;
  int miscompares = 0;
  vec_t vecs[$];

  delay_tap_reader #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_DELAY  (MAX_DELAY),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .data_i    (data_i),
    .delay_i   (delay_i),
    .frac_i    (frac_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .overrun_o (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input int data, input int dly, input int frac,
                               input int expected, input string name);
    int edges;
    @(negedge clk);
    en      = 1'b1;
    data_i  = DATA_WIDTH'(data);
    delay_i = 4'(dly);
    frac_i  = 4'(frac);
    @(negedge clk);
    en    = 1'b0;
    edges = 0;
    while (!valid_o && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    checkOutput({name, " latency"}, edges, LAT);
    checkOutput({name, " data"}, int'(data_o), expected);
    if (ready_i) @(negedge clk);
  endtask

  initial begin
    int pulses;
    int changed;
    int dropped_valid;

    for (int k = 1; k <= 10; k++)
      vecs.push_back('{(k == 1), k, 3, 0, (k >= 4) ? k - 3 : 0});
    vecs.push_back('{1'b0, -1234, 0, 0, -1234});
    for (int k = 1; k <= 40; k++)
      vecs.push_back('{(k == 1), k, 15, 0, (k >= 16) ? k - 15 : 0});

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset data_o", int'(data_o), 0);
    checkOutput("reset valid_o", int'(valid_o), 0);
    checkOutput("reset overrun_o", int'(overrun_o), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_reset) resetDut();
      applyStimulus(vecs[i].data, vecs[i].dly, vecs[i].frac, vecs[i].exp_data,
                    $sformatf("vec%0d", i));
    end

    // Backpressure: hold the output, drop a second request, then read it back.
    resetDut();
    ready_i = 1'b0;
    applyStimulus(5, 0, 0, 5, "bp first");
    pulses = 0;
    changed = 0;
    dropped_valid = 0;
    for (int i = 0; i < 12; i++) begin
      en     = (i == 3);
      data_i = DATA_WIDTH'(77);
      @(negedge clk);
      if (overrun_o) pulses++;
      if (data_o !== DATA_WIDTH'(5)) changed++;
      if (!valid_o) dropped_valid++;
    end
    en = 1'b0;
    checkOutput("bp overrun pulses", pulses, 1);
    checkOutput("bp data changes", changed, 0);
    checkOutput("bp valid drops", dropped_valid, 0);
    ready_i = 1'b1;
    @(negedge clk);
    checkOutput("bp valid after accept", int'(valid_o), 0);
    applyStimulus(88, 1, 0, 77, "bp dropped sample");

    // Reset while the output is waiting to be accepted.
    ready_i = 1'b0;
    applyStimulus(9, 0, 0, 9, "rst pending");
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst valid_o", int'(valid_o), 0);
    checkOutput("rst data_o", int'(data_o), 0);
    rst_n   = 1'b1;
    ready_i = 1'b1;
    applyStimulus(11, 1, 0, 0, "rst first");
    applyStimulus(12, 1, 0, 11, "rst second");

`ifdef DELAY_INTERP_EN
    resetDut();
    applyStimulus(100, 0, 8, 50, "interp lone");
    applyStimulus(200, 0, 8, 150, "interp half");
    resetDut();
    applyStimulus(100, 0, 0, 100, "interp zero a");
    applyStimulus(200, 0, 0, 200, "interp zero b");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
